enemy_formation_renderer: RTL

Renders a horizontal row of N 8x8 alien sprites for the VGA pixel pipeline. Each sprite is scaled by SCALE and has a two-frame walk animation. The block owns the formation's motion state machine: march right or left, step down at the screen edges, and halt at the bottom. It also keeps a per-enemy alive mask that collision logic clears through a kill port. It sits between the VGA timing counters and the top-level colour mux, in parallel with the player and shot renderers.

---
 rtl/enemy_pkg.sv | 16 +
 rtl/enemy_formation_renderer_if.sv | 27 ++
 rtl/sprite_bitmap_rom.sv | 20 ++
 rtl/enemy_formation_renderer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy formation renderer.
//   state_t  : formation motion states
//   rgb_t    : 24-bit packed colour {R,G,B}
//   FRAME0/1 : the two 8x8 walk-cycle bitmaps, row 0 first, MSB = leftmost pixel
package enemy_pkg;

  typedef enum logic [1:0] {MARCH_R, MARCH_L, HALT} state_t;

  typedef logic [23:0] rgb_t;

  typedef logic [7:0] bitmap_t [8];

  localparam bitmap_t FRAME0 = '{8'h3C, 8'h7E, 8'hFF, 8'hCF, 8'hFF, 8'h24, 8'h5A, 8'hA5};
  localparam bitmap_t FRAME1 = '{8'h3C, 8'h7E, 8'hFF, 8'hCF, 8'hFF, 8'h24, 8'h42, 8'h81};

endpackage

// File: rtl/enemy_formation_renderer_if.sv
// Pixel / control bus between the VGA timing side and the formation renderer.
//   master : timing/collision side, drives counters, frame_tick and kill requests
//   slave  : renderer, returns the pixel colour and formation status
interface enemy_formation_renderer_if #(parameter int N_ENEMIES = 8);
  logic                 frame_tick;
  logic [9:0]           h_counter;
  logic [9:0]           v_counter;
  logic                 kill_valid;
  logic [3:0]           kill_idx;
  logic [7:0]           R;
  logic [7:0]           G;
  logic [7:0]           B;
  logic                 sprite_on;
  logic [N_ENEMIES-1:0] alive_mask;
  logic                 all_dead;
  logic                 halted;

  modport master (
    output frame_tick, h_counter, v_counter, kill_valid, kill_idx,
    input  R, G, B, sprite_on, alive_mask, all_dead, halted
  );

  modport slave (
    input  frame_tick, h_counter, v_counter, kill_valid, kill_idx,
    output R, G, B, sprite_on, alive_mask, all_dead, halted
  );
endinterface

// File: rtl/sprite_bitmap_rom.sv
// Combinational 8x8 sprite lookup, two animation frames.
//   frame : animation frame select
//   row   : bitmap row 0..7 (top to bottom)
//   col   : bitmap column 0..7 (left to right)
//   pix   : 1 when the pixel is lit
module sprite_bitmap_rom
  import enemy_pkg::*;
(
  input  logic       frame,
  input  logic [2:0] row,
  input  logic [2:0] col,
  output logic       pix
);
  logic [7:0] line;

  always_comb begin
    line = frame ? FRAME1[row] : FRAME0[row];
    pix  = line[3'd7 - col];  // MSB is the leftmost column
  end
endmodule

// File: rtl/enemy_formation_renderer.sv
// Renders a row of N_ENEMIES scaled 8x8 aliens and owns the formation motion.
//   clk, reset : pixel clock, synchronous active-high reset
//   bus        : slave side of enemy_formation_renderer_if
//                in : frame_tick, h_counter, v_counter, kill_valid, kill_idx
//                out: R, G, B, sprite_on (1-cycle latency), alive_mask, all_dead, halted
module enemy_formation_renderer
  import enemy_pkg::*;
#(
  parameter int   N_ENEMIES = 8,
  parameter int   SCALE     = 3,
  parameter int   SPACING   = 32,
  parameter int   START_X   = 100,
  parameter int   START_Y   = 60,
  parameter int   STEP_X    = 2,
  parameter int   DROP_Y    = 8,
  parameter int   X_MIN     = 8,
  parameter int   X_MAX     = 632,
  parameter int   Y_LIMIT   = 400,
  parameter int   ANIM_DIV  = 16,
  parameter rgb_t COLOR     = 24'hFFFFFF
) (
  input logic clk,
  input logic reset,
  enemy_formation_renderer_if.slave bus
);
  localparam int SPR    = 8 * SCALE;
  localparam int W      = (N_ENEMIES - 1) * SPACING + SPR;
  localparam int LOG_SP = $clog2(SPACING);
  localparam int ACW    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  state_t               state_q, state_d;
  logic [9:0]           x_q, x_d, y_q, y_d;
  logic [N_ENEMIES-1:0] alive_q, alive_d;
  logic                 all_dead_q, halted_q, halted_d;
  logic [ACW-1:0]       anim_cnt_q, anim_cnt_d;
  logic                 anim_frame_q, anim_frame_d;
  logic                 dropped;

  // Motion / animation next state. all_dead_q is the registered flag, so the
  // decision sees the mask as it was before any kill landing this cycle.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    halted_d     = halted_q;
    anim_cnt_d   = anim_cnt_q;
    anim_frame_d = anim_frame_q;
    dropped      = 1'b0;
    if (bus.frame_tick) begin
      case (state_q)
        MARCH_R: begin
          if (all_dead_q) state_d = HALT;
          else if (int'(x_q) + STEP_X + W > X_MAX) begin
            y_d     = y_q + 10'(DROP_Y);
            state_d = MARCH_L;
            dropped = 1'b1;
          end else x_d = x_q + 10'(STEP_X);
        end
        MARCH_L: begin
          if (all_dead_q) state_d = HALT;
          else if (int'(x_q) < X_MIN + STEP_X) begin
            y_d     = y_q + 10'(DROP_Y);
            state_d = MARCH_R;
            dropped = 1'b1;
          end else x_d = x_q - 10'(STEP_X);
        end
        default: ;
      endcase
      if (dropped && int'(y_d) + SPR >= Y_LIMIT) begin
        state_d  = HALT;
        halted_d = 1'b1;
      end
      if (state_q != HALT) begin
        if (int'(anim_cnt_q) == ANIM_DIV - 1) begin
          anim_cnt_d   = '0;
          anim_frame_d = ~anim_frame_q;
        end else anim_cnt_d = anim_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    alive_d = alive_q;
    if (bus.kill_valid && int'(bus.kill_idx) < N_ENEMIES)
      alive_d = alive_q & ~(N_ENEMIES'(1) << bus.kill_idx);
  end

  // Pixel hit test against the current position
  logic signed [10:0] dx, dy;
  logic [9:0]         dxu, dyu;
  logic [LOG_SP-1:0]  lane;
  logic [2:0]         rom_row, rom_col;
  logic               rom_pix, alive_bit, hit;

  always_comb begin
    dx        = $signed({1'b0, bus.h_counter}) - $signed({1'b0, x_q});
    dy        = $signed({1'b0, bus.v_counter}) - $signed({1'b0, y_q});
    dxu       = dx[9:0];
    dyu       = dy[9:0];
    lane      = dxu[LOG_SP-1:0];
    rom_row   = 3'(int'(dyu) / SCALE);
    rom_col   = 3'(int'(lane) / SCALE);
    alive_bit = |(alive_q & (N_ENEMIES'(1) << (int'(dxu) / SPACING)));
    hit       = !dx[10] && !dy[10] && int'(dxu) < W && int'(dyu) < SPR &&
                int'(lane) < SPR && alive_bit && rom_pix;
  end

  sprite_bitmap_rom u_rom (
    .frame (anim_frame_q),
    .row   (rom_row),
    .col   (rom_col),
    .pix   (rom_pix)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= MARCH_R;
      x_q          <= 10'(START_X);
      y_q          <= 10'(START_Y);
      alive_q      <= '1;
      all_dead_q   <= 1'b0;
      halted_q     <= 1'b0;
      anim_cnt_q   <= '0;
      anim_frame_q <= 1'b0;
      bus.R        <= '0;
      bus.G        <= '0;
      bus.B        <= '0;
      bus.sprite_on <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      alive_q      <= alive_d;
      all_dead_q   <= (alive_d == '0);
      halted_q     <= halted_d;
      anim_cnt_q   <= anim_cnt_d;
      anim_frame_q <= anim_frame_d;
      bus.R        <= hit ? COLOR[23:16] : 8'd0;
      bus.G        <= hit ? COLOR[15:8]  : 8'd0;
      bus.B        <= hit ? COLOR[7:0]   : 8'd0;
      bus.sprite_on <= hit;
    end
  end

  assign bus.alive_mask = alive_q;
  assign bus.all_dead   = all_dead_q;
  assign bus.halted     = halted_q;
endmodule
